// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one data memory between the MEM stage (port 0) and a
// secondary master (port 1); screens each granted request for size, alignment and bounds.
module datamem_arbiter #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p0_wdata,
    input  logic [3:0]  p0_size,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [63:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p1_wdata,
    input  logic [3:0]  p1_size,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [63:0] p1_rdata,
    output logic        p1_err,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    localparam int unsigned AW = 64;
    localparam int unsigned SW = 4;
    localparam int unsigned BW = AW + 1;

    logic          last_gnt;
    logic          last_gnt_nxt;
    logic          win_valid;
    logic          win_sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [63:0]   sel_wdata;
    logic [SW-1:0] sel_size;
    logic          legal;

    // Arbitration and winner field selection; reset suppresses any winner
    always_comb begin
        win_valid = 1'b0;
        win_sel   = 1'b0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                win_valid = 1'b1;
                win_sel   = ~last_gnt;
            end else if (p0_req) begin
                win_valid = 1'b1;
            end else if (p1_req) begin
                win_valid = 1'b1;
                win_sel   = 1'b1;
            end
        end
        sel_we    = win_sel ? p1_we    : p0_we;
        sel_addr  = win_sel ? p1_addr  : p0_addr;
        sel_wdata = win_sel ? p1_wdata : p0_wdata;
        sel_size  = win_sel ? p1_size  : p0_size;
    end

    // Bounds sum is one bit wider than the address so wrap-around cannot pass
    always_comb begin
        legal = (sel_size == SW'(1)) || (sel_size == SW'(2)) ||
                (sel_size == SW'(4)) || (sel_size == SW'(8));
        if ((sel_addr & AW'(sel_size - SW'(1))) != '0)
            legal = 1'b0;
        if ((BW'(sel_addr) + BW'(sel_size)) > BW'(MEM_SIZE))
            legal = 1'b0;
    end

    // Round-robin pointer next state
    always_comb begin
        last_gnt_nxt = last_gnt;
        if (win_valid)
            last_gnt_nxt = win_sel;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_gnt <= 1'b1;
        else
            last_gnt <= last_gnt_nxt;
    end

    // Grant and memory control outputs; illegal or absent winners park the bus
    always_comb begin
        p0_gnt           = win_valid && !win_sel;
        p1_gnt           = win_valid &&  win_sel;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_xfer_size    = SW'(8);
        if (win_valid && legal) begin
            mem_write_enable = sel_we;
            mem_read_enable  = ~sel_we;
            mem_address      = sel_addr;
            mem_write_data   = sel_wdata;
            mem_xfer_size    = sel_size;
        end
    end

    // Per-port response registers: one-cycle rvalid/err pulses, rdata held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt && legal && !sel_we;
            p0_err    <= p0_gnt && !legal;
            p1_rvalid <= p1_gnt && legal && !sel_we;
            p1_err    <= p1_gnt && !legal;
            if (p0_gnt && legal && !sel_we)
                p0_rdata <= mem_read_data;
            if (p1_gnt && legal && !sel_we)
                p1_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a byte-array memory model behind the mem_* bus.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_size, p1_size;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_xfer_size;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    datamem_arbiter #(.MEM_SIZE(1024)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
    );

    // Memory model: little-endian, low xfer_size bytes, writes on the rising edge
    always @(posedge clk) begin
        if (mem_write_enable)
            for (int i = 0; i < 8; i++)
                if (i < int'(mem_xfer_size))
                    mem[10'(mem_address + 64'(i))] <= mem_write_data[i*8 +: 8];
    end

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            if (i < int'(mem_xfer_size))
                mem_read_data[i*8 +: 8] = mem[10'(mem_address + 64'(i))];
    end

    task automatic drive_p0(input logic req, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [3:0] size);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size;
    endtask

    task automatic drive_p1(input logic req, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [3:0] size);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size;
    endtask

    task automatic idle();
        drive_p0(1'b0, 1'b0, 64'h0, 64'h0, 4'd8);
        drive_p1(1'b0, 1'b0, 64'h0, 64'h0, 4'd8);
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1; idle();
        @(negedge clk); drive_p0(1'b1, 1'b0, 64'h40, 64'h0, 4'd8); #1;
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", p0_gnt); end
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_ren got %b exp 0", mem_read_enable); end
        checks++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin errors++; $display("FAIL rst_pulses got %b exp 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
        checks++; if ({p0_rdata, p1_rdata} !== 128'h0) begin errors++; $display("FAIL rst_rdata got %h_%h exp 0", p0_rdata, p1_rdata); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL post_rst_gnt got %b exp 1", p0_gnt); end
        @(negedge clk); idle(); #1;
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL post_rst_rvalid got %b exp 1", p0_rvalid); end
    endtask

    task automatic test_single();
        @(negedge clk); drive_p0(1'b1, 1'b1, 64'h40, 64'h1122334455667788, 4'd8); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL single_wr_gnt got %b exp 1", p0_gnt); end
        checks++; if ({mem_write_enable, mem_read_enable} !== 2'b10) begin errors++; $display("FAIL single_wr_en got %b exp 10", {mem_write_enable, mem_read_enable}); end
        checks++; if (mem_address !== 64'h40) begin errors++; $display("FAIL single_wr_addr got %h exp 40", mem_address); end
        @(negedge clk); drive_p0(1'b1, 1'b0, 64'h40, 64'h0, 4'd8); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL single_rd_gnt got %b exp 1", p0_gnt); end
        checks++; if ({p0_rvalid, p0_err} !== 2'b00) begin errors++; $display("FAIL single_wr_resp got %b exp 00", {p0_rvalid, p0_err}); end
        @(negedge clk); idle(); #1;
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b exp 1", p0_rvalid); end
        checks++; if (p0_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL single_rdata got %h exp 1122334455667788", p0_rdata); end
        @(negedge clk); #1;
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", p0_rvalid); end
        checks++; if (p0_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL single_hold got %h exp 1122334455667788", p0_rdata); end
    endtask

    task automatic test_contention();
        logic ep0, ep1, ev0, ev1;
        @(negedge clk); reset = 1'b1; idle();
        @(negedge clk); reset = 1'b0;
        drive_p0(1'b1, 1'b0, 64'h40, 64'h0, 4'd8);
        drive_p1(1'b1, 1'b0, 64'h48, 64'h0, 4'd8);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            ep0 = (i % 2 == 0);
            ep1 = (i % 2 == 1);
            ev0 = (i > 0) && ((i - 1) % 2 == 0);
            ev1 = (i > 0) && ((i - 1) % 2 == 1);
            checks++; if ({p0_gnt, p1_gnt} !== {ep0, ep1}) begin errors++; $display("FAIL cont_gnt[%0d] got %b exp %b", i, {p0_gnt, p1_gnt}, {ep0, ep1}); end
            checks++; if ({p0_rvalid, p1_rvalid} !== {ev0, ev1}) begin errors++; $display("FAIL cont_rvalid[%0d] got %b exp %b", i, {p0_rvalid, p1_rvalid}, {ev0, ev1}); end
        end
        @(negedge clk); idle(); #1;
        checks++; if ({p0_rvalid, p1_rvalid} !== 2'b01) begin errors++; $display("FAIL cont_last_rvalid got %b exp 01", {p0_rvalid, p1_rvalid}); end
        checks++; if (p0_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL cont_p0_rdata got %h exp 1122334455667788", p0_rdata); end
    endtask

    task automatic test_illegal();
        logic [63:0] addrs [4];
        logic [3:0]  sizes [4];
        addrs = '{64'h3, 64'h3FC, 64'h10, 64'h3F8};
        sizes = '{4'd4, 4'd8, 4'd3, 4'd8};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive_p1(1'b1, 1'b0, addrs[i], 64'h0, sizes[i]); #1;
            checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL ill_gnt[%0d] got %b exp 1", i, p1_gnt); end
            checks++; if (mem_read_enable !== (i == 3)) begin errors++; $display("FAIL ill_ren[%0d] got %b exp %b", i, mem_read_enable, (i == 3)); end
            if (i < 3) begin
                checks++; if ({mem_address, mem_xfer_size} !== {64'h0, 4'd8}) begin errors++; $display("FAIL ill_park[%0d] got %h/%0d exp 0/8", i, mem_address, mem_xfer_size); end
            end
            @(negedge clk); idle(); #1;
            checks++; if ({p1_err, p1_rvalid} !== ((i == 3) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL ill_resp[%0d] got %b exp %b", i, {p1_err, p1_rvalid}, ((i == 3) ? 2'b01 : 2'b10)); end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk); drive_p0(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'd8); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL wrap_gnt got %b exp 1", p0_gnt); end
        checks++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin errors++; $display("FAIL wrap_en got %b exp 00", {mem_write_enable, mem_read_enable}); end
        @(negedge clk); idle(); #1;
        checks++; if ({p0_err, p0_rvalid} !== 2'b10) begin errors++; $display("FAIL wrap_resp got %b exp 10", {p0_err, p0_rvalid}); end
    endtask

    task automatic test_collision();
        @(negedge clk); reset = 1'b1; idle();
        @(negedge clk); reset = 1'b0;
        drive_p0(1'b1, 1'b1, 64'h100, 64'hAB, 4'd1);
        drive_p1(1'b1, 1'b0, 64'h100, 64'h0, 4'd1); #1;
        checks++; if ({p0_gnt, p1_gnt, mem_write_enable} !== 3'b101) begin errors++; $display("FAIL coll_first got %b exp 101", {p0_gnt, p1_gnt, mem_write_enable}); end
        @(negedge clk); drive_p0(1'b0, 1'b0, 64'h0, 64'h0, 4'd8); #1;
        checks++; if ({p0_gnt, p1_gnt, mem_read_enable} !== 3'b011) begin errors++; $display("FAIL coll_second got %b exp 011", {p0_gnt, p1_gnt, mem_read_enable}); end
        @(negedge clk); idle(); #1;
        checks++; if (p1_rvalid !== 1'b1) begin errors++; $display("FAIL coll_rvalid got %b exp 1", p1_rvalid); end
        checks++; if (p1_rdata !== 64'hAB) begin errors++; $display("FAIL coll_rdata got %h exp ab", p1_rdata); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive_p0(1'b1, 1'b0, 64'h8, 64'h0, 4'd1); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL mid_pre_gnt got %b exp 1", p0_gnt); end
        @(negedge clk); reset = 1'b1; drive_p0(1'b1, 1'b1, 64'h8, 64'hFF, 4'd1); #1;
        checks++; if ({p0_gnt, mem_write_enable} !== 2'b00) begin errors++; $display("FAIL mid_rst got %b exp 00", {p0_gnt, mem_write_enable}); end
        @(negedge clk); reset = 1'b0;
        drive_p0(1'b1, 1'b0, 64'h8, 64'h0, 4'd1);
        drive_p1(1'b1, 1'b0, 64'h8, 64'h0, 4'd1); #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL mid_tie got %b exp 10", {p0_gnt, p1_gnt}); end
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL mid_pulse_clr got %b exp 0", p0_rvalid); end
        @(negedge clk); drive_p0(1'b0, 1'b0, 64'h0, 64'h0, 4'd8); #1;
        checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 64'h0}) begin errors++; $display("FAIL mid_rd got %b/%h exp 1/0", p0_rvalid, p0_rdata); end
        checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL mid_p1_gnt got %b exp 1", p1_gnt); end
        @(negedge clk); idle(); #1;
        checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 64'h0}) begin errors++; $display("FAIL mid_p1_rd got %b/%h exp 1/0", p1_rvalid, p1_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset = 1'b1;
        idle();
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_wrap();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port round-robin arbiter that shares the single-ported, 1024-byte data memory between the pipeline MEM stage (port 0) and a secondary master such as a loader or debug port (port 1). It grants at most one access per cycle and checks each request for alignment, power-of-two size and bounds before it reaches memory. Illegal requests are refused with an error pulse. Read data is registered and returned per port one cycle after the grant. It sits directly in front of the data memory and drives all of that memory's control inputs.

## Interface
- MEM_SIZE, 1024: memory size in bytes; must be a power of two greater than 8.
- clk  in  1  single clock; memory writes occur on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pN_req  in  1  port N (N = 0, 1) request; held until pN_gnt.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  64  byte address.
- pN_wdata  in  64  write data, little-endian; low pN_size bytes used.
- pN_size  in  4  transfer size in bytes (1, 2, 4 or 8).
- pN_gnt  out  1  combinational; request accepted this cycle.
- pN_rvalid  out  1  registered; pN_rdata valid this cycle.
- pN_rdata  out  64  registered read data.
- pN_err  out  1  registered; the previously granted request was illegal.
- mem_address  out  64  to memory address.
- mem_write_enable  out  1  to memory write enable.
- mem_read_enable  out  1  to memory read enable.
- mem_write_data  out  64  to memory write data.
- mem_xfer_size  out  4  to memory transfer size.
- mem_read_data  in  64  combinational read data from memory.

## Operation
- State: last_gnt (1 bit, the port granted most recently), plus per-port rvalid, err and rdata registers.
- Arbitration (combinational, every cycle):
  - If only one port has req = 1, that port wins.
  - If both ports have req = 1, the port that is not last_gnt wins.
  - If neither port has req = 1, there is no winner.
- Exactly one pN_gnt is high when there is a winner; both are low otherwise. last_gnt updates to the winner at the clock edge and holds when there is no winner.
- Legality checks on the winner, all of which must pass:
  - size is 1, 2, 4 or 8;
  - (addr & (size-1)) == 0;
  - addr + size <= MEM_SIZE, computed in 65 bits so wrap-around is caught.
- Legal winner: the mem_* outputs mirror the winner's fields. mem_write_enable = we and mem_read_enable = ~we.
- Illegal winner or no winner: both enables are 0. mem_address, mem_write_data and mem_xfer_size are driven to 0, 0 and 8.
- Illegal requests are still granted, which consumes them, but they never reach memory.
- Next-cycle results at each edge:
  - Winner was a legal read: pN_rvalid <= 1 and pN_rdata <= mem_read_data.
  - Winner was illegal: pN_err <= 1, rvalid stays 0 and rdata holds.
  - Legal write: no rvalid and no err.
- rvalid and err are single-cycle pulses. rdata holds its value until the next legal read on the same port.

## Timing
- Grant latency is 0 cycles: gnt rises in the same cycle req is presented if the port wins.
- A write commits at the rising edge that ends the grant cycle.
- Read latency is 1 cycle: rvalid and rdata appear in the cycle after gnt. err likewise appears in the cycle after gnt.
- A port may present its next request in the cycle after its gnt. Back-to-back grants to one port are allowed when the other port is idle.
- With both ports requesting continuously, grants strictly alternate. The maximum wait is 1 cycle.
- Reset values: last_gnt = 1, so port 0 wins the first tie. All rvalid and err = 0, all rdata = 0.
- Reset is active during a cycle:
  - all gnt and both mem enables are forced to 0;
  - no write commits;
  - rvalid and err pulses due from the previous cycle are cleared at that edge.
- A requester whose req is still high when reset deasserts is arbitrated normally in the first cycle after reset.
- pN_req dropping before gnt withdraws the request with no side effects.

## Test plan
- Single port: p0 writes 0x1122334455667788 to addr 0x40 with size 8, then reads addr 0x40 with size 8 -> p0_gnt is high in each request cycle, and p0_rvalid is high with p0_rdata = 0x1122334455667788 one cycle after the read grant.
- Contention: both ports request reads every cycle starting from reset -> grant order is p0, p1, p0, p1. Each rvalid lags its gnt by exactly 1 cycle and is never high on both ports in the same cycle.
- Illegal requests: p1 reads addr 0x3 with size 4, then addr 0x3FC with size 8, then addr 0x10 with size 3 -> each gets p1_gnt, p1_err is high the next cycle, mem_read_enable stays 0 and p1_rvalid stays 0.
- Wrap-around: p0 reads addr 0xFFFFFFFFFFFFFFF8 with size 8 -> p0_err is asserted and the memory is not enabled.
- Write vs read collision: p0 writes byte 0xAB to addr 0x100 while p1 reads addr 0x100 with size 1 in the same cycle, last_gnt = 1 -> p0 is granted first. p1 is granted next cycle, and p1_rdata[7:0] = 0xAB.
- Reset mid-operation: assert reset in the cycle p0 is granted a write of 0xFF to addr 0x8 (previously 0x00) -> gnt is forced low and no write occurs. After reset, a read of addr 0x8 returns 0x00 and the first tie goes to p0.
